button_debouncer_array: RTL



---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 99 +++++++++
 rtl/button_debouncer_array.sv | 35 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer family.
package debounce_pkg;

    // Debounced-level encoding, after the input polarity has been normalised
    localparam logic BUTTON_PRESSED  = 1'b1;
    localparam logic BUTTON_RELEASED = 1'b0;

    // Ceiling log2 for sizing counters; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 0) ? value - 1 : 0;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce counter, press/release pulses
// and optional long-press detection.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          INPUT_ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_raw,
    output logic button_level,
    output logic button_press,
    output logic button_release,
    output logic button_long_press
);

    localparam int unsigned         DB_W         = clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]     DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic                RAW_RELEASED = BUTTON_RELEASED ^ INPUT_ACTIVE_LOW;

    logic            sync_meta;
    logic            sync_stable;
    logic            pressed;
    logic [DB_W-1:0] db_count;

    // Two-flop synchroniser, parked at the idle pin level during reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta   <= RAW_RELEASED;
            sync_stable <= RAW_RELEASED;
        end else begin
            sync_meta   <= button_raw;
            sync_stable <= sync_meta;
        end
    end

    // Normalised so that 1 always means pressed
    assign pressed = sync_stable ^ INPUT_ACTIVE_LOW;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_count       <= '0;
            button_level   <= BUTTON_RELEASED;
            button_press   <= 1'b0;
            button_release <= 1'b0;
        end else begin
            button_press   <= 1'b0;
            button_release <= 1'b0;
            if (pressed == button_level) begin
                db_count <= '0;
            end else if (db_count == DB_LAST) begin
                db_count       <= '0;
                button_level   <= pressed;
                button_press   <= (pressed == BUTTON_PRESSED);
                button_release <= (pressed == BUTTON_RELEASED);
            end else begin
                db_count <= db_count + 1'b1;
            end
        end
    end

    if (LONG_PRESS_CYCLES > 0) begin : g_long_press
        localparam int unsigned       HOLD_W    = clog2(LONG_PRESS_CYCLES + 1);
        localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

        logic [HOLD_W-1:0] hold_count;
        logic              fired;

        // Hold counter starts the cycle after the press pulse, so firing on
        // HOLD_LAST lands the pulse LONG_PRESS_CYCLES cycles after the press;
        // it then freezes until the level drops.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                hold_count        <= '0;
                fired             <= 1'b0;
                button_long_press <= 1'b0;
            end else begin
                button_long_press <= 1'b0;
                if (button_level != BUTTON_PRESSED) begin
                    hold_count <= '0;
                    fired      <= 1'b0;
                end else if (!fired) begin
                    if (hold_count == HOLD_LAST) begin
                        fired             <= 1'b1;
                        button_long_press <= 1'b1;
                    end else begin
                        hold_count <= hold_count + 1'b1;
                    end
                end
            end
        end
    end else begin : g_no_long_press
        assign button_long_press = 1'b0;
    end

endmodule

// File: rtl/button_debouncer_array.sv
// Multi-channel push-button conditioner: one independent debounce_channel per pin.
module button_debouncer_array
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          INPUT_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_CHANNELS-1:0] button_raw,
    output logic [NUM_CHANNELS-1:0] button_level,
    output logic [NUM_CHANNELS-1:0] button_press,
    output logic [NUM_CHANNELS-1:0] button_release,
    output logic [NUM_CHANNELS-1:0] button_long_press
);

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
            .INPUT_ACTIVE_LOW  (INPUT_ACTIVE_LOW)
        ) u_channel (
            .clock             (clock),
            .reset_n           (reset_n),
            .button_raw        (button_raw[ch]),
            .button_level      (button_level[ch]),
            .button_press      (button_press[ch]),
            .button_release    (button_release[ch]),
            .button_long_press (button_long_press[ch])
        );
    end

endmodule
